// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: redirect controls and ROM port on one side,
// IF/ID stage and fault status on the other.
interface fetch_ctrl_if #(
    parameter int N  = 64,
    parameter int AW = 7
);
    logic          stall;
    logic          branch_taken;
    logic [N-1:0]  branch_target;
    logic          exc_req;
    logic          eret;
    logic [N-1:0]  elr_in;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic [31:0]   if_instr;
    logic [N-1:0]  if_pc;
    logic          if_valid;
    logic          fetch_exc;
    logic [N-1:0]  fault_pc;
    logic [31:0]   fetch_count;

    // Seen from the fetch sequencer.
    modport slave (
        input  stall, branch_taken, branch_target, exc_req, eret, elr_in, imem_q,
        output imem_addr, if_instr, if_pc, if_valid, fetch_exc, fault_pc, fetch_count
    );

    // Seen from the surrounding core / ROM.
    modport master (
        output stall, branch_taken, branch_target, exc_req, eret, elr_in, imem_q,
        input  imem_addr, if_instr, if_pc, if_valid, fetch_exc, fault_pc, fetch_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the instruction ROM,
// loads IF/ID, applies redirects and reports fetch faults.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal fetch; sequential step, stall hold or fault detect
// ST_FAULT | PC frozen on a faulting address, IF/ID bubbled until redirect
module fetch_ctrl #(
    parameter int              N       = 64,
    parameter int              AW      = 7,
    parameter logic [N-1:0]    EXC_VEC = 64'h0000_0000_0000_00D8,
    parameter logic [31:0]     NOP     = 32'h8B1F03FF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fetch_ctrl_if.slave io_fc
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_pc;
    logic [31:0]    r_if_instr;
    logic [N-1:0]   r_if_pc;
    logic           r_if_valid;
    logic           r_fetch_exc;
    logic [N-1:0]   r_fault_pc;
    logic [31:0]    r_fetch_count;

    logic           w_fault;
    logic           w_redirect;
    logic [N-1:0]   w_redirect_pc;
    logic [31:0]    w_count_inc;

    // Fault when misaligned or beyond the last ROM word; pick redirect target by priority.
    always_comb begin
        w_fault       = (r_pc[1:0] != 2'b00) || (r_pc[N-1:AW+2] != '0);
        w_redirect    = io_fc.exc_req || io_fc.eret || io_fc.branch_taken;
        w_redirect_pc = r_pc;
        if (io_fc.exc_req) begin
            w_redirect_pc = EXC_VEC;
        end else if (io_fc.eret) begin
            w_redirect_pc = io_fc.elr_in;
        end else if (io_fc.branch_taken) begin
            w_redirect_pc = io_fc.branch_target;
        end
        w_count_inc = (r_fetch_count == 32'hFFFF_FFFF) ? r_fetch_count : r_fetch_count + 32'd1;
    end

    // PC, IF/ID and fault state machine; redirects override both states.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_RUN;
            r_pc          <= '0;
            r_if_instr    <= NOP;
            r_if_pc       <= '0;
            r_if_valid    <= 1'b0;
            r_fetch_exc   <= 1'b0;
            r_fault_pc    <= '0;
            r_fetch_count <= '0;
        end else if (w_redirect) begin
            // The word fetched this cycle is wrong-path; one bubble follows.
            r_state     <= ST_RUN;
            r_pc        <= w_redirect_pc;
            r_if_instr  <= NOP;
            r_if_valid  <= 1'b0;
            r_fetch_exc <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_fault) begin
                        r_state     <= ST_FAULT;
                        r_fetch_exc <= 1'b1;
                        r_fault_pc  <= r_pc;
                        r_if_instr  <= NOP;
                        r_if_valid  <= 1'b0;
                    end else if (!io_fc.stall) begin
                        r_if_instr    <= io_fc.imem_q;
                        r_if_pc       <= r_pc;
                        r_if_valid    <= 1'b1;
                        r_pc          <= r_pc + N'(4);
                        r_fetch_count <= w_count_inc;
                    end
                end
                ST_FAULT: begin
                    r_if_instr <= NOP;
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign io_fc.imem_addr   = r_pc[AW+1:2];
    assign io_fc.if_instr    = r_if_instr;
    assign io_fc.if_pc       = r_if_pc;
    assign io_fc.if_valid    = r_if_valid;
    assign io_fc.fetch_exc   = r_fetch_exc;
    assign io_fc.fault_pc    = r_fault_pc;
    assign io_fc.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl against a behavioural fetch model.
module tb_fetch_ctrl;
    localparam int          N       = 64;
    localparam int          AW      = 7;
    localparam logic [63:0] EXC_VEC = 64'hD8;
    localparam logic [31:0] NOP     = 32'h8B1F03FF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.N(N), .AW(AW)) ifc ();
    logic [31:0] rom [128];
    assign ifc.imem_q = rom[ifc.imem_addr];

    fetch_ctrl #(.N(N), .AW(AW), .EXC_VEC(EXC_VEC), .NOP(NOP)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_fc   (ifc)
    );

    // Behavioural model of the fetch pipeline.
    logic [63:0] m_pc, m_ifpc, m_fpc;
    logic [31:0] m_instr, m_cnt;
    bit          m_fault, m_valid, m_fexc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ifpc = 0; m_fpc = 0; m_instr = NOP; m_cnt = 0;
        m_fault = 0; m_valid = 0; m_fexc = 0;
    endtask

    function automatic bit pc_bad(input logic [63:0] p);
        return ((p % 64'd4) != 0) || (p >= 64'd512);
    endfunction

    task automatic redirect(input logic [63:0] t);
        m_pc = t; m_instr = NOP; m_valid = 0; m_fault = 0; m_fexc = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        if (ifc.exc_req)           redirect(EXC_VEC);
        else if (ifc.eret)         redirect(ifc.elr_in);
        else if (ifc.branch_taken) redirect(ifc.branch_target);
        else if (m_fault) begin
            m_instr = NOP; m_valid = 0;
        end else if (pc_bad(m_pc)) begin
            m_fault = 1; m_fexc = 1; m_fpc = m_pc; m_instr = NOP; m_valid = 0;
        end else if (!ifc.stall) begin
            m_instr = rom[int'((m_pc / 64'd4) % 64'd128)];
            m_ifpc  = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 64'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/addr"},  64'(ifc.imem_addr), (m_pc / 64'd4) % 64'd128);
        chk({tag, "/instr"}, 64'(ifc.if_instr), 64'(m_instr));
        chk({tag, "/valid"}, 64'(ifc.if_valid), 64'(m_valid));
        chk({tag, "/fexc"},  64'(ifc.fetch_exc), 64'(m_fexc));
        chk({tag, "/count"}, 64'(ifc.fetch_count), 64'(m_cnt));
        if (m_valid) chk({tag, "/ifpc"}, ifc.if_pc, m_ifpc);
        if (m_fexc)  chk({tag, "/fpc"}, ifc.fault_pc, m_fpc);
    endtask

    task automatic cyc(input bit st, input bit br, input logic [63:0] tgt,
                       input bit ex, input bit er, input logic [63:0] elr, input string tag);
        ifc.stall = st; ifc.branch_taken = br; ifc.branch_target = tgt;
        ifc.exc_req = ex; ifc.eret = er; ifc.elr_in = elr;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        ifc.stall = 0; ifc.branch_taken = 0; ifc.branch_target = 0;
        ifc.exc_req = 0; ifc.eret = 0; ifc.elr_in = 0;
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        rom[0] = 32'hF8000001;
        model_reset();

        #12;
        check_all("reset");
        chk("reset_ifpc", ifc.if_pc, 64'd0);
        chk("reset_fpc", ifc.fault_pc, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_addr", 64'(ifc.imem_addr), 64'd0);

        cyc(0, 0, 0, 0, 0, 0, "e1");
        chk("e1_instr", 64'(ifc.if_instr), 64'hF8000001);
        chk("e1_ifpc", ifc.if_pc, 64'd0);
        chk("e1_valid", 64'(ifc.if_valid), 64'd1);
        chk("e1_addr", 64'(ifc.imem_addr), 64'd1);
        chk("e1_cnt", 64'(ifc.fetch_count), 64'd1);

        cyc(0, 0, 0, 0, 0, 0, "e2");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0, "stall");
            chk("stall_addr", 64'(ifc.imem_addr), 64'd2);
            chk("stall_ifpc", ifc.if_pc, 64'd4);
            chk("stall_cnt", 64'(ifc.fetch_count), 64'd2);
        end
        cyc(0, 0, 0, 0, 0, 0, "unstall");
        chk("unstall_ifpc", ifc.if_pc, 64'd8);
        chk("unstall_instr", 64'(ifc.if_instr), 64'(rom[2]));
        cyc(0, 0, 0, 0, 0, 0, "to10");

        cyc(0, 1, 64'h40, 0, 0, 0, "br40");
        chk("br40_valid", 64'(ifc.if_valid), 64'd0);
        chk("br40_instr", 64'(ifc.if_instr), 64'(NOP));
        cyc(0, 0, 0, 0, 0, 0, "br40_tgt");
        chk("br40_ifpc", ifc.if_pc, 64'h40);
        chk("br40_word", 64'(ifc.if_instr), 64'(rom[16]));

        cyc(0, 1, 64'h40, 1, 0, 0, "excbr");
        chk("excbr_addr", 64'(ifc.imem_addr), 64'd54);
        cyc(0, 0, 0, 0, 0, 0, "excbr_tgt");
        chk("excbr_ifpc", ifc.if_pc, 64'hD8);
        cyc(0, 0, 0, 0, 1, 64'h24, "eret");
        cyc(0, 0, 0, 0, 0, 0, "eret_tgt");
        chk("eret_ifpc", ifc.if_pc, 64'h24);

        cyc(0, 1, 64'h42, 0, 0, 0, "mis_flush");
        chk("mis_flush_fexc", 64'(ifc.fetch_exc), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, "mis_fault");
        chk("mis_fexc", 64'(ifc.fetch_exc), 64'd1);
        chk("mis_fpc", ifc.fault_pc, 64'h42);
        for (int i = 0; i < 5; i++) begin
            cyc(bit'(i % 2), 0, 0, 0, 0, 0, "mis_hold");
            chk("mis_hold_valid", 64'(ifc.if_valid), 64'd0);
            chk("mis_hold_fexc", 64'(ifc.fetch_exc), 64'd1);
        end
        cyc(0, 0, 0, 1, 0, 0, "mis_exc");
        chk("mis_exc_fexc", 64'(ifc.fetch_exc), 64'd0);
        chk("mis_exc_addr", 64'(ifc.imem_addr), 64'd54);

        cyc(0, 1, 64'h1FC, 0, 0, 0, "end_br");
        cyc(0, 0, 0, 0, 0, 0, "end_w127");
        chk("end_ifpc", ifc.if_pc, 64'h1FC);
        chk("end_word", 64'(ifc.if_instr), 64'(rom[127]));
        cyc(0, 0, 0, 0, 0, 0, "end_fault");
        chk("end_fexc", 64'(ifc.fetch_exc), 64'd1);
        chk("end_fpc", ifc.fault_pc, 64'h200);

        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async");
        chk("async_fpc", ifc.fault_pc, 64'd0);
        chk("async_ifpc", ifc.if_pc, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, "restart");
        chk("restart_ifpc", ifc.if_pc, 64'd0);
        chk("restart_word", 64'(ifc.if_instr), 64'hF8000001);

        for (int i = 0; i < 400; i++) begin
            logic [63:0] tgt, elr;
            tgt = ($urandom % 16 == 0) ? 64'($urandom_range(0, 1023)) : 64'($urandom_range(0, 127) * 4);
            elr = ($urandom % 16 == 0) ? 64'($urandom_range(0, 1023)) : 64'($urandom_range(0, 127) * 4);
            cyc(($urandom % 4) == 0, ($urandom % 8) == 0, tgt,
                ($urandom % 16) == 0, ($urandom % 16) == 0, elr, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
